// File: rtl/deglitch_pkg.sv
// Shared constants and helpers for the deglitch_multi glitch filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package deglitch_pkg;

  // Default counter/threshold width; max programmable threshold is 2^CNT_W-1.
  localparam int DEF_CNT_W       = 4;
  // Default synchroniser depth when the synchroniser is built in.
  localparam int DEF_SYNC_STAGES = 2;

  // A programmed threshold of 0 would mean "accept nothing ever"; treat it as 1
  // so the filter degenerates to a plain registered pass-through.
  function automatic logic [31:0] eff_thresh(input logic [31:0] thr);
    return (thr == 32'd0) ? 32'd1 : thr;
  endfunction

endpackage

// File: rtl/deglitch_chan.sv
// One deglitch channel: optional synchroniser, run-length counter, level and strobe registers.
// Latency: T edges from s change to data_out change (plus SYNC_STAGES when DEGLITCH_SYNC_EN is defined).
// Backpressure: none; free-running, every output is a registered one-cycle strobe or level.
import deglitch_pkg::*;

module deglitch_chan #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             data_in,
  output logic             data_out,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic             glitch_pls
);

  // Depth below two offers no metastability protection, so refuse to build.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("deglitch_chan: SYNC_STAGES must be >= 2");
  end

  logic s;

`ifdef DEGLITCH_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain; oldest bit feeds the filter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  // Source is already synchronous to clk; filter it directly.
  assign s = data_in;
`endif

  // One extra bit so cnt+1 can never wrap before it is compared to T.
  logic [CNT_W:0]   thr_eff;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_q;

  assign thr_eff = (CNT_W+1)'(eff_thresh(32'(cfg_thresh)));
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Count cycles that s disagrees with data_out; switch once the run reaches T,
  // and flag a glitch when a nonzero run collapses back to the current level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      data_out   <= 1'b0;
      rise_pls   <= 1'b0;
      fall_pls   <= 1'b0;
      glitch_pls <= 1'b0;
    end else begin
      rise_pls   <= 1'b0;
      fall_pls   <= 1'b0;
      glitch_pls <= 1'b0;
      if (s == data_out) begin
        cnt_q      <= '0;
        glitch_pls <= (cnt_q != '0);
      end else if (cnt_inc >= thr_eff) begin
        cnt_q    <= '0;
        data_out <= s;
        rise_pls <= s;
        fall_pls <= ~s;
      end else begin
        cnt_q <= cnt_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/deglitch_multi.sv
// Multi-channel glitch filter; build with DEGLITCH_SYNC_EN defined to add a per-channel synchroniser.
// Latency: T edges (SYNC_STAGES + T with DEGLITCH_SYNC_EN) from stable data_in change to data_out.
// Backpressure: none; channels free-run independently and share one threshold.
import deglitch_pkg::*;

module deglitch_multi #(
  parameter int CH          = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [CH-1:0]    data_in,
  output logic [CH-1:0]    data_out,
  output logic [CH-1:0]    rise_pls,
  output logic [CH-1:0]    fall_pls,
  output logic [CH-1:0]    glitch_pls
);

  // Degenerate sizes would produce zero-width buses.
  if (CH < 1) begin : g_bad_ch
    $error("deglitch_multi: CH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("deglitch_multi: CNT_W must be >= 1");
  end

  // One fully independent filter per input bit, all sharing cfg_thresh.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    deglitch_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk        (clk),
      .rstn       (rstn),
      .cfg_thresh (cfg_thresh),
      .data_in    (data_in[gi]),
      .data_out   (data_out[gi]),
      .rise_pls   (rise_pls[gi]),
      .fall_pls   (fall_pls[gi]),
      .glitch_pls (glitch_pls[gi])
    );
  end

endmodule

// File: tb/tb_deglitch_multi.sv
// Randomised and directed bench for deglitch_multi against a run-length reference model.
// Latency: expectations account for the synchroniser only when DEGLITCH_SYNC_EN is defined.
// Backpressure: n/a.
module tb_deglitch_multi;

  localparam int CH    = 4;
  localparam int CNT_W = 4;
  localparam int SS    = 2;
`ifdef DEGLITCH_SYNC_EN
  localparam int SYNC_LAT = SS;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [CNT_W-1:0] cfg_thresh;
  logic [CH-1:0]    data_in;
  logic [CH-1:0]    data_out;
  logic [CH-1:0]    rise_pls;
  logic [CH-1:0]    fall_pls;
  logic [CH-1:0]    glitch_pls;

  int n_checks = 0;
  int n_errors = 0;

  deglitch_multi #(
    .CH          (CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_thresh (cfg_thresh),
    .data_in    (data_in),
    .data_out   (data_out),
    .rise_pls   (rise_pls),
    .fall_pls   (fall_pls),
    .glitch_pls (glitch_pls)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers its recent filter-input samples and
  // switches once the trailing run of samples differing from the output is T long.
  logic [CH-1:0] m_out, m_rise, m_fall, m_gl;
  logic [31:0]   m_hist [CH];
  int            m_hlen [CH];
`ifdef DEGLITCH_SYNC_EN
  logic [CH-1:0] m_pipe [SS];
`endif

  task automatic model_reset();
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
    m_gl   = '0;
    for (int c = 0; c < CH; c++) begin
      m_hist[c] = '0;
      m_hlen[c] = 0;
    end
`ifdef DEGLITCH_SYNC_EN
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
`endif
  endtask

  function automatic int trailing(input int c);
    int n = 0;
    for (int i = 0; i < m_hlen[c]; i++) begin
      if (m_hist[c][i] == m_out[c]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step(input logic [CH-1:0] din, input logic [CNT_W-1:0] thr);
    int            t;
    int            prev;
    logic [CH-1:0] s;
    t = (thr == '0) ? 1 : int'(thr);
`ifdef DEGLITCH_SYNC_EN
    s = m_pipe[SS-1];
    for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = din;
`else
    s = din;
`endif
    m_rise = '0;
    m_fall = '0;
    m_gl   = '0;
    for (int c = 0; c < CH; c++) begin
      prev = trailing(c);
      m_hist[c] = {m_hist[c][30:0], s[c]};
      if (m_hlen[c] < 32) m_hlen[c]++;
      if (s[c] == m_out[c]) begin
        m_gl[c] = (prev > 0);
      end else if (prev + 1 >= t) begin
        m_out[c]  = s[c];
        m_rise[c] = s[c];
        m_fall[c] = ~s[c];
      end
    end
  endtask

  // One clock: sample after the edge, advance the model, compare, return at the negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step(data_in, cfg_thresh);
    check("data_out",   32'(data_out),   32'(m_out));
    check("rise_pls",   32'(rise_pls),   32'(m_rise));
    check("fall_pls",   32'(fall_pls),   32'(m_fall));
    check("glitch_pls", 32'(glitch_pls), 32'(m_gl));
    @(negedge clk);
  endtask

  initial begin
    int gl_cnt, rise_cnt, fall_cnt, hi_cnt, rise_at, fall_at, rise2_at, other_act;
    int hold [CH];

    // Reset state
    rstn       = 1'b0;
    data_in    = '0;
    cfg_thresh = 4'd4;
    model_reset();
    #3;
    check("rst_data_out",   32'(data_out),   32'd0);
    check("rst_rise_pls",   32'(rise_pls),   32'd0);
    check("rst_fall_pls",   32'(fall_pls),   32'd0);
    check("rst_glitch_pls", 32'(glitch_pls), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // T=4, 3-cycle pulse is rejected with exactly one glitch strobe
    gl_cnt = 0; rise_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      data_in[0] = (i < 3);
      cyc();
      gl_cnt   += int'(glitch_pls[0]);
      rise_cnt += int'(rise_pls[0]);
      hi_cnt   += int'(data_out[0]);
    end
    check("short_glitch_cnt", 32'(gl_cnt),   32'd1);
    check("short_rise_cnt",   32'(rise_cnt), 32'd0);
    check("short_out_high",   32'(hi_cnt),   32'd0);

    // T=4, 4-cycle pulse passes with rise and fall at full latency
    rise_at = -1; fall_at = -1; rise_cnt = 0; fall_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      data_in[0] = (i <= 4);
      cyc();
      if (data_out[0] && rise_at < 0) rise_at = i;
      if (!data_out[0] && rise_at > 0 && fall_at < 0) fall_at = i;
      rise_cnt += int'(rise_pls[0]);
      fall_cnt += int'(fall_pls[0]);
    end
    check("pass_rise_latency", 32'(rise_at),  32'(SYNC_LAT + 4));
    check("pass_fall_edge",    32'(fall_at),  32'(4 + SYNC_LAT + 4));
    check("pass_rise_cnt",     32'(rise_cnt), 32'd1);
    check("pass_fall_cnt",     32'(fall_cnt), 32'd1);

    // Threshold 0 behaves as 1: single-cycle pulse passes, never a glitch
    cfg_thresh = 4'd0;
    hi_cnt = 0; gl_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      data_in[0] = (i == 1);
      cyc();
      hi_cnt += int'(data_out[0]);
      gl_cnt += int'(glitch_pls != '0);
    end
    check("t0_out_width",  32'(hi_cnt), 32'd1);
    check("t0_glitch_cnt", 32'(gl_cnt), 32'd0);

    // Channel independence: ch1 chatters, ch2 steps high, ch0/ch3 idle
    cfg_thresh = 4'd4;
    gl_cnt = 0; hi_cnt = 0; rise2_at = -1; other_act = 0;
    for (int i = 1; i <= 40; i++) begin
      data_in[1] = ((i / 2) % 2) == 1;
      data_in[2] = 1'b1;
      cyc();
      gl_cnt += int'(glitch_pls[1]);
      hi_cnt += int'(data_out[1]);
      if (data_out[2] && rise2_at < 0) rise2_at = i;
      other_act += int'(data_out[0] | data_out[3] | rise_pls[0] | rise_pls[3] |
                        fall_pls[0] | fall_pls[3] | glitch_pls[0] | glitch_pls[3]);
    end
    data_in[1] = 1'b0;
    check("chatter_glitch_ge8", 32'(gl_cnt >= 8), 32'd1);
    check("chatter_out_high",   32'(hi_cnt),      32'd0);
    check("step_ch2_latency",   32'(rise2_at),    32'(SYNC_LAT + 4));
    check("idle_ch0_ch3_act",   32'(other_act),   32'd0);

    // Asynchronous reset mid-count, then a held-high input rises at full latency
    data_in[0] = 1'b1;
    for (int i = 0; i < SYNC_LAT + 2; i++) cyc();
    check("pre_rst_ch2_high", 32'(data_out[2]), 32'd1);
    rstn = 1'b0;
    #1;
    model_reset();
    check("arst_data_out",   32'(data_out),   32'd0);
    check("arst_rise_pls",   32'(rise_pls),   32'd0);
    check("arst_fall_pls",   32'(fall_pls),   32'd0);
    check("arst_glitch_pls", 32'(glitch_pls), 32'd0);
    #1;
    rstn = 1'b1;
    rise_at = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (data_out[0] && rise_at < 0) rise_at = i;
    end
    check("post_rst_rise_latency", 32'(rise_at), 32'(SYNC_LAT + 4));

    // Lowering the threshold mid-run switches on the very next edge
    cfg_thresh = 4'd8;
    data_in[3] = 1'b1;
    for (int i = 0; i < SYNC_LAT + 5; i++) cyc();
    check("thr8_ch3_still_low", 32'(data_out[3]), 32'd0);
    cfg_thresh = 4'd3;
    cyc();
    check("thr3_ch3_switched", 32'(data_out[3]), 32'd1);
    check("thr3_ch3_rise",     32'(rise_pls[3]), 32'd1);

    // Randomised hold lengths and thresholds across all channels
    for (int c = 0; c < CH; c++) hold[c] = int'($urandom_range(1, 9));
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) cfg_thresh = CNT_W'($urandom_range(0, 6));
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          data_in[c] = ~data_in[c];
          hold[c]    = int'($urandom_range(0, 9));
        end else begin
          hold[c]--;
        end
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
